// File: rtl/fx_pkg.sv
// Shared definitions for the seven-segment effects select sequencer:
// mode encodings, select width and the masked-advance helper.
package fx_pkg;

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_AUTO   = 2'b01;
    localparam logic [1:0] MODE_STEP   = 2'b10;

    localparam int SEL_W        = 4;
    localparam int NUM_PATTERNS = 2 ** SEL_W;

    typedef enum logic [1:0] {
        ST_MANUAL = 2'b00,
        ST_AUTO   = 2'b01,
        ST_STEP   = 2'b10
    } fx_state_e;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } next_sel_t;

    // Scan upward from sel+1 (wrapping) for the first unmasked pattern; sel itself is never a hit.
    function automatic next_sel_t next_unmasked(input logic [SEL_W-1:0]        sel,
                                                input logic [NUM_PATTERNS-1:0] mask);
        next_sel_t        res;
        logic [SEL_W-1:0] cand;
        res.found = 1'b0;
        res.idx   = sel;
        for (int i = 1; i < NUM_PATTERNS; i++) begin
            cand = sel + SEL_W'(i);
            if (!res.found && !mask[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fx_select_sequencer_debounce.sv
// Button conditioning: two-flop synchroniser, run-length debounce and
// rising-edge press detection that ignores a button held through reset.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic [1:0]    fill_r;
    logic [CW-1:0] cnt_r;
    logic          level_r;
    logic          press_r;
    logic          armed_r;

    // Synchronise, debounce and detect presses; arming needs a low level after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            fill_r  <= 2'd0;
            cnt_r   <= '0;
            level_r <= 1'b0;
            press_r <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            sync1_r <= i_btn;
            sync2_r <= sync1_r;
            press_r <= 1'b0;
            if (fill_r != 2'd2) begin
                fill_r <= fill_r + 2'd1;
            end
            if (sync2_r != level_r) begin
                if (cnt_r == CNT_LAST) begin
                    level_r <= sync2_r;
                    cnt_r   <= '0;
                    press_r <= sync2_r & armed_r;
                    if (!sync2_r) begin
                        armed_r <= 1'b1;
                    end
                end else begin
                    cnt_r <= cnt_r + CW'(1);
                end
            end else begin
                cnt_r <= '0;
                // Until the synchroniser holds a real sample it still shows its reset value.
                if ((fill_r == 2'd2) && !level_r) begin
                    armed_r <= 1'b1;
                end
            end
        end
    end

    assign o_level = level_r;
    assign o_press = press_r;

endmodule

// File: rtl/fx_select_sequencer.sv
// Pattern select sequencer: manual, auto (dwell on counter wraps) and step
// (button) modes, with masked advance and a change pulse for downstream logic.
module fx_select_sequencer
    import fx_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DWELL_WRAPS     = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [1:0]              i_mode,
    input  logic [SEL_W-1:0]        i_manual_sel,
    input  logic                    i_btn_next,
    input  logic [NUM_PATTERNS-1:0] i_skip_mask,
    input  logic                    i_count_wrap,
    output logic [SEL_W-1:0]        o_sel,
    output logic                    o_changed,
    output logic [1:0]              o_mode
);

    localparam int DW = (DWELL_WRAPS > 1) ? $clog2(DWELL_WRAPS) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_WRAPS - 1);

    logic [1:0]       mode_s1_r;
    logic [1:0]       mode_s2_r;
    fx_state_e        state_r;
    fx_state_e        next_state_s;
    logic [SEL_W-1:0] sel_r;
    logic             changed_r;
    logic [DW-1:0]    dwell_r;
    logic             btn_level_s;
    logic             btn_press_s;
    logic             press_s;
    next_sel_t        adv_s;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_btn  (i_btn_next),
        .o_level(btn_level_s),
        .o_press(btn_press_s)
    );

    // Two-flop synchroniser for the asynchronous mode pins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_s1_r <= 2'b00;
            mode_s2_r <= 2'b00;
        end else begin
            mode_s1_r <= i_mode;
            mode_s2_r <= mode_s1_r;
        end
    end

    // Decode the synced mode and precompute the masked advance target.
    always_comb begin
        next_state_s = ST_MANUAL;
        case (mode_s2_r)
            MODE_AUTO: next_state_s = ST_AUTO;
            MODE_STEP: next_state_s = ST_STEP;
            default:   next_state_s = ST_MANUAL;
        endcase
        press_s = btn_press_s & btn_level_s;
        adv_s   = next_unmasked(sel_r, i_skip_mask);
    end

    // Mode FSM with select register, dwell counter and change pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= ST_MANUAL;
            sel_r     <= '0;
            changed_r <= 1'b0;
            dwell_r   <= '0;
        end else begin
            changed_r <= 1'b0;
            if (next_state_s != state_r) begin
                // Events coinciding with a mode switch are dropped; the new rules start next cycle.
                state_r <= next_state_s;
                dwell_r <= '0;
            end else begin
                case (state_r)
                    ST_MANUAL: begin
                        sel_r     <= i_manual_sel;
                        changed_r <= (i_manual_sel != sel_r);
                        dwell_r   <= '0;
                    end
                    ST_AUTO: begin
                        if (press_s || (i_count_wrap && (dwell_r == DWELL_LAST))) begin
                            dwell_r <= '0;
                            if (adv_s.found) begin
                                sel_r     <= adv_s.idx;
                                changed_r <= 1'b1;
                            end
                        end else if (i_count_wrap) begin
                            dwell_r <= dwell_r + DW'(1);
                        end
                    end
                    ST_STEP: begin
                        dwell_r <= '0;
                        if (press_s && adv_s.found) begin
                            sel_r     <= adv_s.idx;
                            changed_r <= 1'b1;
                        end
                    end
                    default: begin
                        state_r <= ST_MANUAL;
                        dwell_r <= '0;
                    end
                endcase
            end
        end
    end

    assign o_sel     = sel_r;
    assign o_changed = changed_r;
    assign o_mode    = state_r;

endmodule

// File: tb/tb_fx_select_sequencer.sv
// Directed self-checking bench for fx_select_sequencer (DWELL_WRAPS=2, DEBOUNCE_CYCLES=4).
module tb_fx_select_sequencer;
    import fx_pkg::*;

    logic                    clk;
    logic                    rst_n;
    logic [1:0]              mode;
    logic [SEL_W-1:0]        manual_sel;
    logic                    btn;
    logic [NUM_PATTERNS-1:0] mask;
    logic                    wrap;
    logic [SEL_W-1:0]        sel;
    logic                    changed;
    logic [1:0]              mode_out;

    int vectors;
    int miscompares;
    int chg_cnt;

    fx_select_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .DWELL_WRAPS    (2)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_mode      (mode),
        .i_manual_sel(manual_sel),
        .i_btn_next  (btn),
        .i_skip_mask (mask),
        .i_count_wrap(wrap),
        .o_sel       (sel),
        .o_changed   (changed),
        .o_mode      (mode_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            chg_cnt += int'(changed);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_wrap();
        wrap = 1'b1;
        tick(1);
        wrap = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        chg_cnt     = 0;
        rst_n       = 1'b0;
        mode        = 2'b00;
        manual_sel  = 4'd9;
        btn         = 1'b0;
        mask        = 16'h0000;
        wrap        = 1'b0;

        // 1. reset values, then manual load
        tick(2);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_changed", 32'(changed), 32'd0);
        check("rst_mode", 32'(mode_out), 32'd0);
        rst_n = 1'b1;
        tick(1);
        check("man_sel9", 32'(sel), 32'd9);
        check("man_chg9", 32'(changed), 32'd1);
        tick(1);
        check("man_chg_drop", 32'(changed), 32'd0);

        // 2. auto advance every 2nd wrap, and wrap-around 15->0
        manual_sel = 4'd3;
        tick(1);
        check("man_sel3", 32'(sel), 32'd3);
        mode = 2'b01;
        tick(4);
        check("auto_mode", 32'(mode_out), 32'd1);
        pulse_wrap();
        check("auto_w1", 32'(sel), 32'd3);
        pulse_wrap();
        check("auto_w2", 32'(sel), 32'd4);
        check("auto_w2_chg", 32'(changed), 32'd1);
        tick(1);
        check("auto_chg_drop", 32'(changed), 32'd0);
        pulse_wrap();
        pulse_wrap();
        check("auto_w4", 32'(sel), 32'd5);
        mode       = 2'b00;
        manual_sel = 4'd15;
        tick(5);
        check("man_sel15", 32'(sel), 32'd15);
        mode = 2'b01;
        tick(4);
        pulse_wrap();
        pulse_wrap();
        check("auto_wrap15", 32'(sel), 32'd0);

        // 3. step mode: glitch rejected, clean presses advance once each
        mode = 2'b10;
        tick(4);
        check("step_mode", 32'(mode_out), 32'd2);
        btn = 1'b1;
        tick(3);
        btn = 1'b0;
        tick(10);
        check("step_glitch", 32'(sel), 32'd0);
        pulse_wrap();
        pulse_wrap();
        check("step_wrap_ign", 32'(sel), 32'd0);
        btn = 1'b1;
        tick(10);
        check("step_press1", 32'(sel), 32'd1);
        btn = 1'b0;
        tick(10);
        check("step_release", 32'(sel), 32'd1);
        btn = 1'b1;
        tick(10);
        check("step_press2", 32'(sel), 32'd2);
        btn = 1'b0;
        tick(10);

        // 4. masking: only 0 unmasked holds; 0x00F0 skips 4..7
        mode       = 2'b00;
        manual_sel = 4'd0;
        tick(5);
        mask = 16'hFFFE;
        mode = 2'b01;
        tick(4);
        chg_cnt = 0;
        for (int i = 0; i < 6; i++) pulse_wrap();
        btn = 1'b1;
        tick(10);
        btn = 1'b0;
        tick(10);
        btn = 1'b1;
        tick(10);
        btn = 1'b0;
        tick(10);
        check("mask_hold_sel", 32'(sel), 32'd0);
        check("mask_no_chg", 32'(chg_cnt), 32'd0);
        mask       = 16'h00F0;
        mode       = 2'b00;
        manual_sel = 4'd3;
        tick(5);
        mode = 2'b01;
        tick(4);
        pulse_wrap();
        pulse_wrap();
        check("mask_skip8", 32'(sel), 32'd8);
        btn = 1'b1;
        tick(10);
        check("auto_press9", 32'(sel), 32'd9);
        btn = 1'b0;
        tick(10);

        // 5. press coincides with dwell expiry: single advance, dwell cleared
        pulse_wrap();
        check("sim_pre", 32'(sel), 32'd9);
        btn = 1'b1;
        tick(6);
        wrap = 1'b1;
        tick(1);
        wrap = 1'b0;
        check("sim_sel", 32'(sel), 32'd10);
        check("sim_chg", 32'(changed), 32'd1);
        tick(3);
        check("sim_single", 32'(sel), 32'd10);
        pulse_wrap();
        check("sim_dwell0", 32'(sel), 32'd10);
        pulse_wrap();
        check("sim_dwell_adv", 32'(sel), 32'd11);
        btn = 1'b0;
        tick(10);

        // 6. reset mid-auto with dwell=1 and button held
        btn = 1'b1;
        tick(10);
        check("pre_rst_press", 32'(sel), 32'd12);
        pulse_wrap();
        check("pre_rst_dwell", 32'(sel), 32'd12);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sel", 32'(sel), 32'd0);
        check("mid_rst_mode", 32'(mode_out), 32'd0);
        check("mid_rst_chg", 32'(changed), 32'd0);
        manual_sel = 4'd0;
        tick(2);
        rst_n = 1'b1;
        tick(15);
        check("post_rst_mode", 32'(mode_out), 32'd1);
        check("held_no_press", 32'(sel), 32'd0);
        pulse_wrap();
        check("post_rst_dwell", 32'(sel), 32'd0);
        btn = 1'b0;
        tick(10);
        check("release_no_adv", 32'(sel), 32'd0);
        btn = 1'b1;
        tick(10);
        check("repress_adv", 32'(sel), 32'd1);
        btn = 1'b0;
        tick(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
